// File: rtl/td4_sequencer_if.sv
// Host command port of the TD4 run-control sequencer.
// A command transfers on a rising clock edge where cmd_valid and cmd_ready are both high.
interface td4_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_addr, output cmd_data,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_addr, input  cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/td4_sequencer.sv
// Run-control sequencer for the TD4 core: run/halt/step, program load and core reset.
// Define TD4_SEQ_BREAKPOINT_EN to build the PC breakpoint; otherwise SET_BP/CLR_BP act as NOPs.
module td4_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  td4_sequencer_if.slave     cmd,
  input  logic [3:0]         pc_in,
  output logic               cpu_en,
  output logic               cpu_clr,
  output logic               prog_we,
  output logic [3:0]         prog_addr,
  output logic [7:0]         prog_data,
  output logic               halted,
  output logic               bp_hit,
  output logic               cmd_err,
  output logic [CNT_W-1:0]   cycles
);

  typedef enum logic [2:0] {
    OP_NOP, OP_RUN, OP_HALT, OP_STEP, OP_LOAD, OP_RSTCPU, OP_SET_BP, OP_CLR_BP
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_LOAD, S_RSTCPU
  } state_e;

  localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

  state_e     state, state_nxt;
  op_e        op;
  logic       accept;
  logic       active;
  logic       block;
  logic       err_nxt;
  logic [4:0] remaining;

  assign op            = op_e'(cmd.cmd_op);
  assign active        = (state == S_RUN) || (state == S_STEP);
  assign cmd.cmd_ready = !rst && (active || state == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cpu_en        = active && !block;
  assign cpu_clr       = (state == S_RSTCPU);
  assign prog_we       = (state == S_LOAD);
  assign halted        = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_RUN:    state_nxt = S_RUN;
            OP_STEP:   state_nxt = S_STEP;
            OP_LOAD:   state_nxt = S_LOAD;
            OP_RSTCPU: state_nxt = S_RSTCPU;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        // While executing only HALT and NOP are meaningful; anything else is dropped loudly.
        if (accept && op != OP_HALT && op != OP_NOP)
          err_nxt = 1'b1;
        if (block || (accept && op == OP_HALT) ||
            (state == S_STEP && cpu_en && remaining == 5'd1))
          state_nxt = S_IDLE;
      end
      S_LOAD, S_RSTCPU: state_nxt = S_IDLE;
      default:          state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err   <= 1'b0;
      remaining <= 5'd0;
      prog_addr <= 4'd0;
      prog_data <= 8'd0;
      cycles    <= '0;
    end else begin
      cmd_err <= err_nxt;
      if (state == S_IDLE && accept && op == OP_STEP)
        remaining <= (cmd.cmd_data[3:0] == 4'd0) ? 5'd16 : {1'b0, cmd.cmd_data[3:0]};
      else if (state == S_STEP && cpu_en)
        remaining <= remaining - 5'd1;
      if (state == S_IDLE && accept && op == OP_LOAD) begin
        prog_addr <= cmd.cmd_addr;
        prog_data <= cmd.cmd_data;
      end
      if (state == S_RSTCPU)
        cycles <= '0;
      else if (cpu_en && cycles != '1)
        cycles <= cycles + CYC_ONE;
    end
  end

`ifdef TD4_SEQ_BREAKPOINT_EN
  logic       bp_en;
  logic       skip;
  logic [3:0] bp_addr;

  // skip lets a resumed RUN/STEP execute the instruction sitting on the breakpoint address.
  assign block = bp_en && (pc_in == bp_addr) && !skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_en   <= 1'b0;
      bp_addr <= 4'd0;
      skip    <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      if (state == S_IDLE && accept) begin
        case (op)
          OP_RUN, OP_STEP: begin
            skip   <= 1'b1;
            bp_hit <= 1'b0;
          end
          OP_RSTCPU: bp_hit <= 1'b0;
          OP_SET_BP: begin
            bp_en   <= 1'b1;
            bp_addr <= cmd.cmd_addr;
          end
          OP_CLR_BP: bp_en <= 1'b0;
          default: ;
        endcase
      end else if (cpu_en) begin
        skip <= 1'b0;
      end
      if (active && block)
        bp_hit <= 1'b1;
    end
  end
`else
  logic unused_pc;

  assign unused_pc = ^pc_in;
  assign block     = 1'b0;
  assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: per-cycle expected outputs are queued when a
// command is issued and compared at each falling edge; a tiny core model advances pc_in.
module tb_td4_sequencer;

  localparam int CW = 6;
  localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3,
                         OP_LOAD = 3'd4, OP_RSTCPU = 3'd5, OP_SET_BP = 3'd6;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    pc_in;
  logic          cpu_en, cpu_clr, prog_we, halted, bp_hit, cmd_err;
  logic [3:0]    prog_addr;
  logic [7:0]    prog_data;
  logic [CW-1:0] cycles;

  td4_sequencer_if cmd();

  td4_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .pc_in(pc_in),
    .cpu_en(cpu_en), .cpu_clr(cpu_clr), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .halted(halted), .bp_hit(bp_hit), .cmd_err(cmd_err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  en;
    logic  hlt;
    logic  rdy;
    logic  we;
    logic  clr;
    logic  err;
    logic  bp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   we_pulses = 0;
  logic en_s = 1'b0;
  logic clr_s = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input string tag, input logic en, hlt, rdy, we, clr, err, bp);
    exp_t e;
    e.tag = tag; e.en = en; e.hlt = hlt; e.rdy = rdy;
    e.we = we; e.clr = clr; e.err = err; e.bp = bp;
    exp_q.push_back(e);
  endtask

  task automatic pushIdle(input string tag, input logic bp);
    pushExp(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, bp);
  endtask

  task automatic pushRun(input string tag, input int n);
    for (int i = 0; i < n; i++)
      pushExp(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushReset(input string tag);
    pushExp(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_addr  = addr;
    cmd.cmd_data  = data;
    nextCycle();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_NOP;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      nextCycle();
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic doRstCpu(input string tag);
    pushIdle(tag, 1'b0);
    pushExp(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pushIdle(tag, 1'b0);
    applyStimulus(OP_RSTCPU, 4'd0, 8'd0);
    waitDrain();
    checkOutput({tag, ".cycles"}, cycles, 0);
  endtask

  always @(negedge clk) begin
    en_s  = cpu_en;
    clr_s = cpu_clr;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput({cur.tag, ".cpu_en"},    cpu_en,        cur.en);
      checkOutput({cur.tag, ".halted"},    halted,        cur.hlt);
      checkOutput({cur.tag, ".cmd_ready"}, cmd.cmd_ready, cur.rdy);
      checkOutput({cur.tag, ".prog_we"},   prog_we,       cur.we);
      checkOutput({cur.tag, ".cpu_clr"},   cpu_clr,       cur.clr);
      checkOutput({cur.tag, ".cmd_err"},   cmd_err,       cur.err);
      checkOutput({cur.tag, ".bp_hit"},    bp_hit,        cur.bp);
    end
  end

  always @(posedge prog_we) we_pulses++;

  // Minimal core: PC advances on every enabled cycle and returns to 0 on CPU_CLR.
  initial begin
    pc_in = 4'd0;
    forever begin
      nextCycle();
      if (rst || clr_s) pc_in = 4'd0;
      else if (en_s)    pc_in = pc_in + 4'd1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    rst = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_NOP;
    cmd.cmd_addr  = 4'd0;
    cmd.cmd_data  = 8'd0;
    #2 rst = 1'b1;
    repeat (2) nextCycle();

    pushReset("reset");
    checkOutput("reset.cycles", cycles, 0);
    checkOutput("reset.prog_addr", prog_addr, 0);
    checkOutput("reset.prog_data", prog_data, 0);
    waitDrain();
    rst = 1'b0;

    // LOAD from IDLE: single write pulse with latched address/data
    pushIdle("load", 1'b0);
    pushExp("load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushIdle("load", 1'b0);
    applyStimulus(OP_LOAD, 4'd3, 8'hB7);
    checkOutput("load.prog_addr", prog_addr, 4'd3);
    checkOutput("load.prog_data", prog_data, 8'hB7);
    waitDrain();

    // STEP 3 then STEP 0 (meaning 16)
    pushIdle("step3", 1'b0);
    pushRun("step3", 3);
    pushIdle("step3", 1'b0);
    applyStimulus(OP_STEP, 4'd0, 8'h03);
    waitDrain();
    checkOutput("step3.cycles", cycles, 3);

    pushIdle("step16", 1'b0);
    pushRun("step16", 16);
    pushIdle("step16", 1'b0);
    applyStimulus(OP_STEP, 4'd0, 8'h00);
    waitDrain();
    checkOutput("step16.cycles", cycles, 19);

    doRstCpu("rstcpu1");

    // RUN, HALT presented in the 11th enabled cycle
    pushIdle("run_halt", 1'b0);
    pushRun("run_halt", 11);
    pushIdle("run_halt", 1'b0);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    repeat (10) nextCycle();
    applyStimulus(OP_HALT, 4'd0, 8'd0);
    waitDrain();
    checkOutput("run_halt.cycles", cycles, 11);

    // Illegal commands while running are dropped with an error pulse
    pushIdle("run_drop", 1'b0);
    pushRun("run_drop", 2);
    pushExp("run_drop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExp("run_drop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pushIdle("run_drop", 1'b0);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    nextCycle();
    applyStimulus(OP_LOAD, 4'd7, 8'h11);
    applyStimulus(OP_SET_BP, 4'd5, 8'd0);
    applyStimulus(OP_HALT, 4'd0, 8'd0);
    waitDrain();
    checkOutput("run_drop.prog_addr", prog_addr, 4'd3);
    checkOutput("run_drop.cycles", cycles, 15);

    // Counter saturation with a 6-bit counter
    doRstCpu("rstcpu2");
    pushIdle("sat", 1'b0);
    pushRun("sat", 70);
    pushIdle("sat", 1'b0);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    repeat (69) nextCycle();
    applyStimulus(OP_HALT, 4'd0, 8'd0);
    waitDrain();
    checkOutput("sat.cycles", cycles, 63);

    doRstCpu("rstcpu3");
    pushIdle("set_bp", 1'b0);
    pushIdle("set_bp", 1'b0);
    applyStimulus(OP_SET_BP, 4'd5, 8'd0);
    waitDrain();
`ifdef TD4_SEQ_BREAKPOINT_EN
    // Breakpoint at 5: halt before executing it, resume past it, halt at the next match
    pushIdle("bp1", 1'b0);
    pushRun("bp1", 5);
    pushExp("bp1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushIdle("bp1", 1'b1);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    waitDrain();
    checkOutput("bp1.cycles", cycles, 5);
    checkOutput("bp1.pc", pc_in, 4'd5);

    pushIdle("bp2", 1'b1);
    pushRun("bp2", 16);
    pushExp("bp2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushIdle("bp2", 1'b1);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    waitDrain();
    checkOutput("bp2.cycles", cycles, 21);

    pushIdle("bp_step", 1'b1);
    pushRun("bp_step", 2);
    pushIdle("bp_step", 1'b0);
    applyStimulus(OP_STEP, 4'd0, 8'h02);
    waitDrain();
    checkOutput("bp_step.cycles", cycles, 23);
`else
    // Without the breakpoint option SET_BP is a NOP and RUN passes PC 5
    pushIdle("nobp", 1'b0);
    pushRun("nobp", 8);
    pushIdle("nobp", 1'b0);
    applyStimulus(OP_RUN, 4'd0, 8'd0);
    repeat (7) nextCycle();
    applyStimulus(OP_HALT, 4'd0, 8'd0);
    waitDrain();
    checkOutput("nobp.cycles", cycles, 8);
`endif

    // Reset asserted mid-STEP
    pushIdle("clr_step", 1'b0);
    pushRun("clr_step", 1);
    pushReset("clr_step");
    pushIdle("clr_step", 1'b0);
    applyStimulus(OP_STEP, 4'd0, 8'h05);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("clr_step.cycles", cycles, 0);
    checkOutput("clr_step.prog_addr", prog_addr, 0);
    nextCycle();
    rst = 1'b0;
    waitDrain();

    // Reset arrives on the same edge that would accept a LOAD
    pushIdle("clr_load", 1'b0);
    pushReset("clr_load");
    pushIdle("clr_load", 1'b0);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_LOAD;
    cmd.cmd_addr  = 4'd9;
    cmd.cmd_data  = 8'h5A;
    @(negedge clk);
    #2 rst = 1'b1;
    nextCycle();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_NOP;
    nextCycle();
    rst = 1'b0;
    checkOutput("clr_load.prog_addr", prog_addr, 0);
    checkOutput("clr_load.prog_data", prog_data, 0);
    waitDrain();

    checkOutput("we_pulses", we_pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Run-control sequencer for the TD4 core. It gates the core's clock enable, loads the 16x8 program memory, and issues a synchronous program reset. It also implements run/halt/single-step and an optional address breakpoint. It sits between a host command port and the core's EN/CLR inputs, program-memory write port and PC output, and decides each cycle whether the core advances.

## Interface
- CNT_W, 16, width of executed-cycle counter CYCLES
- CLK  in  1  system clock, rising edge
- CLR  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  sequencer accepts command (handshake = VALID & READY at rising edge)
- CMD_OP  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 LOAD, 5 RSTCPU, 6 SET_BP, 7 CLR_BP
- CMD_ADDR  in  4  LOAD / SET_BP address
- CMD_DATA  in  8  LOAD data; STEP count in [3:0]
- PC_IN  in  4  current core program counter
- CPU_EN  out  1  core advances one instruction on this clock edge
- CPU_CLR  out  1  synchronous core reset pulse
- PROG_WE / PROG_ADDR[3:0] / PROG_DATA[7:0]  out  program-memory write port
- HALTED  out  1  high in IDLE
- BP_HIT  out  1  sticky: halted by breakpoint; cleared on next accepted RUN/STEP/RSTCPU
- CMD_ERR  out  1  one-cycle pulse: command dropped
- CYCLES  out  CNT_W  count of CPU_EN-high cycles, saturating at all-ones

## Operation
- States: IDLE, RUN, STEP, LOAD, RSTCPU.
- Reset (CLR high): state IDLE; CPU_EN, CPU_CLR, PROG_WE, BP_HIT, CMD_ERR = 0; PROG_ADDR/PROG_DATA = 0; CYCLES = 0; breakpoint disabled; HALTED = 1; CMD_READY = 0 while CLR is high.
- CMD_READY = 1 in IDLE, RUN and STEP; 0 in LOAD and RSTCPU.
- IDLE accepts:
  - RUN → RUN.
  - STEP → STEP with remaining = CMD_DATA[3:0], where 0 means 16.
  - LOAD → LOAD; PROG_ADDR/PROG_DATA latch CMD_ADDR/CMD_DATA.
  - RSTCPU → RSTCPU.
  - SET_BP latches CMD_ADDR and enables the breakpoint; CLR_BP disables it.
  - HALT and NOP have no effect.
- RUN/STEP accept:
  - HALT → IDLE.
  - NOP → no effect.
  - Any other op is accepted, dropped, and pulses CMD_ERR the next cycle.
- LOAD: PROG_WE = 1 for exactly one cycle, then → IDLE.
- RSTCPU: CPU_CLR = 1 for one cycle; CYCLES cleared; then → IDLE.
- CPU_EN is combinational: (state is RUN or STEP) and not block. block = breakpoint enabled & PC_IN == bp_addr & !skip.
- skip is set on acceptance of RUN/STEP and cleared after the first CPU_EN-high cycle. This lets execution resume from the breakpoint address.
- When block is true in RUN/STEP: → IDLE, BP_HIT set, no instruction executed.
- STEP: each CPU_EN-high cycle decrements remaining; the cycle that executes with remaining == 1 transitions to IDLE.
- HALT accepted in the same cycle as breakpoint or last step: → IDLE. BP_HIT is set only if block was true.

## Timing
- Command accepted at edge t; the new state is effective from t+1.
- RUN: CPU_EN first high in cycle t+1.
- STEP N: CPU_EN high for exactly N cycles (absent breakpoint/HALT), starting t+1. HALTED rises the cycle after the last enabled cycle.
- HALT accepted at t: CPU_EN in cycle t is unaffected; it is low from t+1.
- LOAD: PROG_WE high in t+1 only; CMD_READY low in t+1.
- RSTCPU: CPU_CLR high in t+1 only; CYCLES reads 0 from t+2.
- Breakpoint: CPU_EN low in the same cycle PC_IN matches; HALTED and BP_HIT high from the next cycle.
- CLR mid-operation: immediate return to reset values, and any in-flight LOAD write is suppressed.

## Configuration
- TD4_SEQ_BREAKPOINT_EN defined: breakpoint register, skip logic and BP_HIT are implemented as above.
- Not defined: SET_BP/CLR_BP are accepted as NOPs in IDLE and still pulse CMD_ERR in RUN/STEP; block is constant 0; BP_HIT is tied 0.

## Test plan
- LOAD addr 3 data 0xB7 from IDLE → PROG_WE=1, PROG_ADDR=3, PROG_DATA=0xB7 for one cycle; CMD_READY=0 that cycle; then IDLE.
- STEP with CMD_DATA=0x3 → CPU_EN high exactly 3 cycles, CYCLES=3, HALTED=1 afterward. STEP with 0 → 16 cycles.
- RUN, then HALT after 10 cycles → CPU_EN low from the cycle after HALT acceptance. CYCLES=11 if HALT is accepted in the 11th enabled cycle.
- SET_BP addr 5, RUN with PC_IN counting 0..15 → CPU_EN low when PC_IN=5, BP_HIT=1. A second RUN executes at PC 5 and continues; the next match at 5 halts again.
- In RUN, LOAD command → accepted, CMD_ERR pulse, PROG_WE stays 0, still RUN. CYCLES at 2^CNT_W−1 stays saturated.
- CLR asserted mid-STEP and mid-LOAD → outputs at reset values immediately; no PROG_WE pulse. RSTCPU → CPU_CLR one-cycle pulse, CYCLES=0.
